// File: rtl/hazard_controller_if.sv
// Hazard-control bundle between the pipeline datapath and hazard_controller.
// The pipeline side uses the master modport and the controller uses the slave modport.
// When HAZARD_CTRL_PERF_EN is defined, the bundle also carries three performance counters.
interface hazard_controller_if #(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
);
  logic              i_ic_miss;
  logic              i_dc_miss;
  logic              i_dec_valid;
  logic              i_dec_uses_rs;
  logic              i_dec_uses_rt;
  logic [REG_W-1:0]  i_dec_rs_addr;
  logic [REG_W-1:0]  i_dec_rt_addr;
  logic              i_ex_valid;
  logic              i_ex_is_load;
  logic [REG_W-1:0]  i_ex_rw_addr;
  logic              i_ex_mispredict;
  logic [ADDR_W-1:0] i_ex_recovery_target;

  logic              o_pc_stall;
  logic              o_i2d_stall;
  logic              o_i2d_flush;
  logic              o_d2e_stall;
  logic              o_d2e_flush;
  logic              o_e2m_stall;
  logic              o_e2m_flush;
  logic              o_m2w_stall;
  logic              o_m2w_flush;
  logic              o_redirect;
  logic [ADDR_W-1:0] o_redirect_pc;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0]       o_stall_cycles;
  logic [31:0]       o_lu_count;
  logic [31:0]       o_redirect_count;
`endif

  modport master (
`ifdef HAZARD_CTRL_PERF_EN
    input  o_stall_cycles, o_lu_count, o_redirect_count,
`endif
    output i_ic_miss, i_dc_miss, i_dec_valid, i_dec_uses_rs, i_dec_uses_rt,
           i_dec_rs_addr, i_dec_rt_addr, i_ex_valid, i_ex_is_load, i_ex_rw_addr,
           i_ex_mispredict, i_ex_recovery_target,
    input  o_pc_stall, o_i2d_stall, o_i2d_flush, o_d2e_stall, o_d2e_flush,
           o_e2m_stall, o_e2m_flush, o_m2w_stall, o_m2w_flush, o_redirect, o_redirect_pc
  );

  modport slave (
`ifdef HAZARD_CTRL_PERF_EN
    output o_stall_cycles, o_lu_count, o_redirect_count,
`endif
    input  i_ic_miss, i_dc_miss, i_dec_valid, i_dec_uses_rs, i_dec_uses_rt,
           i_dec_rs_addr, i_dec_rt_addr, i_ex_valid, i_ex_is_load, i_ex_rw_addr,
           i_ex_mispredict, i_ex_recovery_target,
    output o_pc_stall, o_i2d_stall, o_i2d_flush, o_d2e_stall, o_d2e_flush,
           o_e2m_stall, o_e2m_flush, o_m2w_stall, o_m2w_flush, o_redirect, o_redirect_pc
  );
endinterface

// File: rtl/hazard_controller.sv
// Central hazard controller: per-stage stall/flush and fetch redirection.
// Hazards are resolved by fixed priority, from highest to lowest:
// d-cache miss, pending redirect, mispredict, load-use, i-cache miss.
// A mispredict that fetch cannot accept is held in PEND until fetch is free.
// Optional feature macro: HAZARD_CTRL_PERF_EN adds saturating performance counters.
//
// state | meaning
// RUN   | normal operation, no redirect outstanding
// PEND  | mispredict target latched in tgt_q, waiting for fetch to accept it
module hazard_controller #(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  logic           clk,
  input  logic           rst,
  hazard_controller_if.slave hz
);

  typedef enum logic {RUN, PEND} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              mp, lu, lu_case;

  logic              pc_stall, i2d_stall, i2d_flush, d2e_stall, d2e_flush;
  logic              e2m_stall, e2m_flush, m2w_stall, m2w_flush, redirect;
  logic [ADDR_W-1:0] redirect_pc;

  assign mp = hz.i_ex_valid & hz.i_ex_mispredict;
  assign lu = hz.i_dec_valid & hz.i_ex_valid & hz.i_ex_is_load & (hz.i_ex_rw_addr != '0) &
              ((hz.i_dec_uses_rs & (hz.i_dec_rs_addr == hz.i_ex_rw_addr)) |
               (hz.i_dec_uses_rt & (hz.i_dec_rt_addr == hz.i_ex_rw_addr)));

  // State register and latched recovery target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  // Priority resolution of hazards into stall/flush/redirect and the next state.
  always_comb begin
    pc_stall    = 1'b0;
    i2d_stall   = 1'b0;
    i2d_flush   = 1'b0;
    d2e_stall   = 1'b0;
    d2e_flush   = 1'b0;
    e2m_stall   = 1'b0;
    e2m_flush   = 1'b0;
    m2w_stall   = 1'b0;
    m2w_flush   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = tgt_q;
    state_d     = state_q;
    tgt_d       = tgt_q;
    lu_case     = 1'b0;
    if (rst) begin
      redirect_pc = '0;
    end else if (hz.i_dc_miss) begin
      // Freeze everything up to M; the held EX branch is re-evaluated once the miss clears.
      pc_stall  = 1'b1;
      i2d_stall = 1'b1;
      d2e_stall = 1'b1;
      e2m_stall = 1'b1;
      m2w_flush = 1'b1;
    end else if (state_q == PEND) begin
      // Anything in EX now is on the wrong path, so its mispredict is ignored.
      i2d_flush = 1'b1;
      pc_stall  = hz.i_ic_miss;
      if (!hz.i_ic_miss) begin
        redirect = 1'b1;
        state_d  = RUN;
      end
    end else if (mp) begin
      i2d_flush = 1'b1;
      d2e_flush = 1'b1;
      if (!hz.i_ic_miss) begin
        redirect    = 1'b1;
        redirect_pc = hz.i_ex_recovery_target;
      end else begin
        pc_stall = 1'b1;
        tgt_d    = hz.i_ex_recovery_target;
        state_d  = PEND;
      end
    end else if (lu) begin
      lu_case   = 1'b1;
      pc_stall  = 1'b1;
      i2d_stall = 1'b1;
      d2e_flush = 1'b1;
    end else if (hz.i_ic_miss) begin
      pc_stall  = 1'b1;
      i2d_flush = 1'b1;
    end
  end

  assign hz.o_pc_stall    = pc_stall;
  assign hz.o_i2d_stall   = i2d_stall;
  assign hz.o_i2d_flush   = i2d_flush;
  assign hz.o_d2e_stall   = d2e_stall;
  assign hz.o_d2e_flush   = d2e_flush;
  assign hz.o_e2m_stall   = e2m_stall;
  assign hz.o_e2m_flush   = e2m_flush;
  assign hz.o_m2w_stall   = m2w_stall;
  assign hz.o_m2w_flush   = m2w_flush;
  assign hz.o_redirect    = redirect;
  assign hz.o_redirect_pc = redirect_pc;

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt, lu_cnt, redir_cnt;

  // Saturating event counters for stall cycles, load-use stalls and redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      lu_cnt    <= '0;
      redir_cnt <= '0;
    end else begin
      if (pc_stall && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (lu_case && (lu_cnt != 32'hFFFF_FFFF))     lu_cnt    <= lu_cnt + 32'd1;
      if (redirect && (redir_cnt != 32'hFFFF_FFFF)) redir_cnt <= redir_cnt + 32'd1;
    end
  end

  assign hz.o_stall_cycles   = stall_cnt;
  assign hz.o_lu_count       = lu_cnt;
  assign hz.o_redirect_count = redir_cnt;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: the stimulus process pushes the
// hand-computed output vector for each cycle, the monitor pops and compares.
module tb_hazard_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_controller_if hz ();

  hazard_controller dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  // flag order: pc_stall, i2d s/f, d2e s/f, e2m s/f, m2w s/f, redirect
  localparam logic [9:0] IDLE = 10'b0_00_00_00_00_0;
  localparam logic [9:0] LU   = 10'b1_10_01_00_00_0;
  localparam logic [9:0] ICM  = 10'b1_01_00_00_00_0;
  localparam logic [9:0] DCM  = 10'b1_10_10_10_01_0;
  localparam logic [9:0] MPR  = 10'b0_01_01_00_00_1;
  localparam logic [9:0] MPS  = 10'b1_01_01_00_00_0;
  localparam logic [9:0] PWT  = 10'b1_01_00_00_00_0;
  localparam logic [9:0] PRD  = 10'b0_01_00_00_00_1;

  typedef struct {
    logic [41:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  bit   stim_done = 1'b0;
  int   n_checks  = 0;
  int   n_fail    = 0;

  task automatic cyc(input logic [9:0] f, input logic [31:0] pc, input string n);
    exp_t e;
    e.v    = {f, pc};
    e.name = n;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hz.i_ic_miss            = 1'b0;
    hz.i_dc_miss            = 1'b0;
    hz.i_dec_valid          = 1'b0;
    hz.i_dec_uses_rs        = 1'b0;
    hz.i_dec_uses_rt        = 1'b0;
    hz.i_dec_rs_addr        = '0;
    hz.i_dec_rt_addr        = '0;
    hz.i_ex_valid           = 1'b0;
    hz.i_ex_is_load         = 1'b0;
    hz.i_ex_rw_addr         = '0;
    hz.i_ex_mispredict      = 1'b0;
    hz.i_ex_recovery_target = '0;
  endtask

  task automatic set_lu(input logic [4:0] rw, input logic urs, input logic [4:0] rs,
                        input logic urt, input logic [4:0] rt);
    hz.i_dec_valid   = 1'b1;
    hz.i_ex_valid    = 1'b1;
    hz.i_ex_is_load  = 1'b1;
    hz.i_ex_rw_addr  = rw;
    hz.i_dec_uses_rs = urs;
    hz.i_dec_rs_addr = rs;
    hz.i_dec_uses_rt = urt;
    hz.i_dec_rt_addr = rt;
  endtask

  task automatic set_mp(input logic [31:0] tgt);
    hz.i_ex_valid           = 1'b1;
    hz.i_ex_mispredict      = 1'b1;
    hz.i_ex_recovery_target = tgt;
  endtask

  // Stimulus
  initial begin
    clr();
    rst = 1'b1;
    @(posedge clk); #1;
    hz.i_ic_miss = 1'b1;
    set_lu(5'd8, 1'b1, 5'd8, 1'b0, 5'd0);
    cyc(IDLE, 32'h0, "reset_forces_zero");
    clr();
    rst = 1'b0;
    cyc(IDLE, 32'h0, "idle_after_reset");

    // load-use
    set_lu(5'd8, 1'b1, 5'd8, 1'b0, 5'd0);  cyc(LU, 32'h0, "lu_rs");
    set_lu(5'd8, 1'b0, 5'd3, 1'b1, 5'd8);  cyc(LU, 32'h0, "lu_rt");
    set_lu(5'd0, 1'b1, 5'd0, 1'b1, 5'd0);  cyc(IDLE, 32'h0, "lu_rw_zero");
    set_lu(5'd8, 1'b0, 5'd8, 1'b0, 5'd8);  cyc(IDLE, 32'h0, "lu_unused_src");
    set_lu(5'd8, 1'b1, 5'd8, 1'b0, 5'd0);
    hz.i_ic_miss = 1'b1;                   cyc(LU, 32'h0, "lu_over_icmiss");
    clr();
    hz.i_ic_miss = 1'b1;                   cyc(ICM, 32'h0, "icmiss_only");
    clr();

    // d-cache miss over load-use and mispredict, then mispredict resolves
    set_lu(5'd8, 1'b1, 5'd8, 1'b0, 5'd0);
    set_mp(32'h0010_0000);
    hz.i_dc_miss = 1'b1;
    for (int i = 0; i < 3; i++) cyc(DCM, 32'h0, "dcmiss_hold");
    hz.i_dc_miss = 1'b0;                   cyc(MPR, 32'h0010_0000, "mp_after_dcmiss");
    clr();

    // mispredict, fetch free
    set_mp(32'h0040_0100);                 cyc(MPR, 32'h0040_0100, "mp_direct");
    clr();                                 cyc(IDLE, 32'h0, "run_after_mp");

    // mispredict with i-cache miss for 4 cycles, second mp ignored in PEND
    set_mp(32'h0040_0200);
    hz.i_ic_miss = 1'b1;                   cyc(MPS, 32'h0, "mp_icmiss_c1");
    set_mp(32'h0040_0300);                 cyc(PWT, 32'h0040_0200, "pend_c2_mp_ignored");
    clr();
    hz.i_ic_miss = 1'b1;                   cyc(PWT, 32'h0040_0200, "pend_c3");
                                           cyc(PWT, 32'h0040_0200, "pend_c4");
    hz.i_ic_miss = 1'b0;                   cyc(PRD, 32'h0040_0200, "pend_redirect");
                                           cyc(IDLE, 32'h0040_0200, "run_after_pend");

    // d-cache miss freezes a pending redirect
    set_mp(32'h0040_0400);
    hz.i_ic_miss = 1'b1;                   cyc(MPS, 32'h0040_0200, "mp_icmiss_b");
    clr();
    hz.i_dc_miss = 1'b1;                   cyc(DCM, 32'h0040_0400, "pend_dcmiss_freeze");
    hz.i_dc_miss = 1'b0;                   cyc(PRD, 32'h0040_0400, "pend_after_dcmiss");
                                           cyc(IDLE, 32'h0040_0400, "run_after_freeze");

    // reset while pending drops the redirect
    set_mp(32'h0040_0500);
    hz.i_ic_miss = 1'b1;                   cyc(MPS, 32'h0040_0400, "mp_icmiss_c");
    clr();
    hz.i_ic_miss = 1'b1;
    rst = 1'b1;                            cyc(IDLE, 32'h0, "reset_in_pend");
    rst = 1'b0;
    hz.i_ic_miss = 1'b0;                   cyc(IDLE, 32'h0, "no_redirect_after_rst");

    // counter workload: 10 load-use cycles and 2 redirects
    set_lu(5'd9, 1'b0, 5'd0, 1'b1, 5'd9);
    for (int i = 0; i < 10; i++) cyc(LU, 32'h0, "perf_lu");
    clr();
    set_mp(32'h0060_0000);                 cyc(MPR, 32'h0060_0000, "perf_redirect1");
    set_mp(32'h0060_0100);                 cyc(MPR, 32'h0060_0100, "perf_redirect2");
    clr();
    stim_done = 1'b1;
  end

  task automatic check(input string n, input logic [41:0] act, input logic [41:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Monitor: compare the DUT outputs on the falling edge against the scoreboard.
  initial begin
    exp_t        e;
    logic [41:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {hz.o_pc_stall, hz.o_i2d_stall, hz.o_i2d_flush, hz.o_d2e_stall, hz.o_d2e_flush,
               hz.o_e2m_stall, hz.o_e2m_flush, hz.o_m2w_stall, hz.o_m2w_flush,
               hz.o_redirect, hz.o_redirect_pc};
        check(e.name, act, e.v);
        check({e.name, "_stall_flush_excl"},
              {38'd0, hz.o_i2d_stall & hz.o_i2d_flush, hz.o_d2e_stall & hz.o_d2e_flush,
               hz.o_e2m_stall & hz.o_e2m_flush, hz.o_m2w_stall & hz.o_m2w_flush},
              42'd0);
      end else if (stim_done) begin
`ifdef HAZARD_CTRL_PERF_EN
        check("lu_count",       {10'd0, hz.o_lu_count},       {10'd0, 32'd10});
        check("redirect_count", {10'd0, hz.o_redirect_count}, {10'd0, 32'd2});
        check("stall_cycles",   {10'd0, hz.o_stall_cycles},   {10'd0, 32'd10});
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

  // Watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
